// File: rtl/multiciclo_control_if.sv
// Signal bundle between the multicycle controller and the datapath it sequences.
// Memory handshake: a request is in flight while mem_req_o=1 and completes in the cycle mem_ready_i=1.
interface multiciclo_control_if #(
   parameter int INSTRET_W = 32
);
   logic [6:0]           opcode_i;
   logic [2:0]           func3_i;
   logic                 func7_i;
   logic                 mem_ready_i;
   logic                 mem_req_o;
   logic                 mem_we_o;
   logic                 addr_sel_o;
   logic                 ir_we_o;
   logic                 pc_we_o;
   logic                 alu_src_a_o;
   logic [1:0]           alu_src_b_o;
   logic                 alu_out_we_o;
   logic [3:0]           alu_op_o;
   logic                 reg_we_o;
   logic                 wb_sel_o;
   logic                 trap_o;
   logic [3:0]           state_o;
   logic [INSTRET_W-1:0] instret_o;

   modport master (
      input  opcode_i, func3_i, func7_i, mem_ready_i,
      output mem_req_o, mem_we_o, addr_sel_o, ir_we_o, pc_we_o, alu_src_a_o,
             alu_src_b_o, alu_out_we_o, alu_op_o, reg_we_o, wb_sel_o, trap_o,
             state_o, instret_o
   );

   modport slave (
      output opcode_i, func3_i, func7_i, mem_ready_i,
      input  mem_req_o, mem_we_o, addr_sel_o, ir_we_o, pc_we_o, alu_src_a_o,
             alu_src_b_o, alu_out_we_o, alu_op_o, reg_we_o, wb_sel_o, trap_o,
             state_o, instret_o
   );
endinterface

// File: rtl/multiciclo_control.sv
// Multicycle main controller: FETCH/DECODE/EXEC/MEM/WB sequencing of a shared ALU,
// memory port and register file, with memory-timeout and illegal-instruction trap.
module multiciclo_control #(
   parameter int MEM_TIMEOUT = 16,
   parameter int INSTRET_W   = 32
) (
   input  logic                clk_i,
   input  logic                rst_n_i,
   multiciclo_control_if.master bus
);

   localparam int CNT_W = $clog2(MEM_TIMEOUT + 1);
   localparam logic [CNT_W-1:0] WAIT_LAST = CNT_W'(MEM_TIMEOUT - 1);

   localparam logic [6:0] OP_R  = 7'b0110011;
   localparam logic [6:0] OP_I  = 7'b0010011;
   localparam logic [6:0] OP_LD = 7'b0000011;
   localparam logic [6:0] OP_ST = 7'b0100011;

   localparam logic [3:0] ALU_ADD  = 4'b0000;
   localparam logic [3:0] ALU_AND  = 4'b0001;
   localparam logic [3:0] ALU_OR   = 4'b0010;
   localparam logic [3:0] ALU_XOR  = 4'b0011;
   localparam logic [3:0] ALU_SUB  = 4'b0100;
   localparam logic [3:0] ALU_SLT  = 4'b0101;
   localparam logic [3:0] ALU_SLTU = 4'b0110;
   localparam logic [3:0] ALU_SLL  = 4'b1000;
   localparam logic [3:0] ALU_SRL  = 4'b1001;
   localparam logic [3:0] ALU_SRA  = 4'b1010;

   typedef enum logic [3:0] {
      S_FETCH  = 4'd0,
      S_DECODE = 4'd1,
      S_EXEC_R = 4'd2,
      S_EXEC_I = 4'd3,
      S_ADDR   = 4'd4,
      S_MEM_RD = 4'd5,
      S_MEM_WR = 4'd6,
      S_WB_ALU = 4'd7,
      S_WB_MEM = 4'd8,
      S_TRAP   = 4'd15
   } state_t;

   typedef struct packed {
      logic       mem_req;
      logic       mem_we;
      logic       addr_sel;
      logic       fetch_en;
      logic       src_a;
      logic [1:0] src_b;
      logic       alu_out_we;
      logic       reg_we;
      logic       wb_sel;
      logic       trap;
   } ctrl_t;

   // Moore decode, evaluated for the state being entered so the outputs are registered.
   function automatic ctrl_t ctrl_of(input state_t s);
      ctrl_t c;
      c = '0;
      case (s)
         S_FETCH:  begin c.mem_req = 1'b1; c.fetch_en = 1'b1; c.src_b = 2'b10; end
         S_EXEC_R: begin c.src_a = 1'b1; c.src_b = 2'b00; c.alu_out_we = 1'b1; end
         S_EXEC_I: begin c.src_a = 1'b1; c.src_b = 2'b01; c.alu_out_we = 1'b1; end
         S_ADDR:   begin c.src_a = 1'b1; c.src_b = 2'b01; c.alu_out_we = 1'b1; end
         S_MEM_RD: begin c.mem_req = 1'b1; c.addr_sel = 1'b1; end
         S_MEM_WR: begin c.mem_req = 1'b1; c.mem_we = 1'b1; c.addr_sel = 1'b1; end
         S_WB_ALU: begin c.reg_we = 1'b1; end
         S_WB_MEM: begin c.reg_we = 1'b1; c.wb_sel = 1'b1; end
         S_TRAP:   begin c.trap = 1'b1; end
         default:  c = '0;
      endcase
      return c;
   endfunction

   function automatic logic [3:0] decode_r_op(input logic f7, input logic [2:0] f3);
      case ({f7, f3})
         4'b0000: return ALU_ADD;
         4'b1000: return ALU_SUB;
         4'b0001: return ALU_SLL;
         4'b0010: return ALU_SLT;
         4'b0011: return ALU_SLTU;
         4'b0100: return ALU_XOR;
         4'b0101: return ALU_SRL;
         4'b1101: return ALU_SRA;
         4'b0110: return ALU_OR;
         4'b0111: return ALU_AND;
         default: return ALU_ADD;
      endcase
   endfunction

   function automatic logic [3:0] decode_i_op(input logic f7, input logic [2:0] f3);
      case (f3)
         3'b000:  return ALU_ADD;
         3'b010:  return ALU_SLT;
         3'b011:  return ALU_SLTU;
         3'b100:  return ALU_XOR;
         3'b110:  return ALU_OR;
         3'b111:  return ALU_AND;
         3'b001:  return ALU_SLL;
         default: return f7 ? ALU_SRA : ALU_SRL;
      endcase
   endfunction

   state_t               r_state;
   ctrl_t                r_ctrl;
   logic [3:0]           r_alu_op;
   logic [CNT_W-1:0]     r_wait;
   logic [INSTRET_W-1:0] r_instret;

   always_ff @(posedge clk_i) begin
      if (!rst_n_i) begin
         r_state   <= S_FETCH;
         r_ctrl    <= ctrl_of(S_FETCH);
         r_alu_op  <= ALU_ADD;
         r_wait    <= '0;
         r_instret <= '0;
      end else begin
         r_alu_op <= ALU_ADD;
         r_wait   <= '0;
         case (r_state)
            S_FETCH: begin
               if (bus.mem_ready_i) begin
                  r_state <= S_DECODE; r_ctrl <= ctrl_of(S_DECODE);
               end else if (r_wait == WAIT_LAST) begin
                  r_state <= S_TRAP; r_ctrl <= ctrl_of(S_TRAP);
               end else begin
                  r_wait <= r_wait + CNT_W'(1);
               end
            end
            S_DECODE: begin
               case (bus.opcode_i)
                  OP_R: begin
                     if (bus.func7_i && bus.func3_i != 3'b000 && bus.func3_i != 3'b101) begin
                        r_state <= S_TRAP; r_ctrl <= ctrl_of(S_TRAP);
                     end else begin
                        r_state  <= S_EXEC_R; r_ctrl <= ctrl_of(S_EXEC_R);
                        r_alu_op <= decode_r_op(bus.func7_i, bus.func3_i);
                     end
                  end
                  OP_I: begin
                     if (bus.func7_i && bus.func3_i == 3'b001) begin
                        r_state <= S_TRAP; r_ctrl <= ctrl_of(S_TRAP);
                     end else begin
                        r_state  <= S_EXEC_I; r_ctrl <= ctrl_of(S_EXEC_I);
                        r_alu_op <= decode_i_op(bus.func7_i, bus.func3_i);
                     end
                  end
                  OP_LD, OP_ST: begin
                     r_state <= S_ADDR; r_ctrl <= ctrl_of(S_ADDR);
                  end
                  default: begin
                     r_state <= S_TRAP; r_ctrl <= ctrl_of(S_TRAP);
                  end
               endcase
            end
            S_EXEC_R, S_EXEC_I: begin
               r_state <= S_WB_ALU; r_ctrl <= ctrl_of(S_WB_ALU);
            end
            S_ADDR: begin
               if (bus.opcode_i == OP_LD) begin
                  r_state <= S_MEM_RD; r_ctrl <= ctrl_of(S_MEM_RD);
               end else begin
                  r_state <= S_MEM_WR; r_ctrl <= ctrl_of(S_MEM_WR);
               end
            end
            S_MEM_RD, S_MEM_WR: begin
               if (bus.mem_ready_i) begin
                  if (r_state == S_MEM_RD) begin
                     r_state <= S_WB_MEM; r_ctrl <= ctrl_of(S_WB_MEM);
                  end else begin
                     r_state   <= S_FETCH; r_ctrl <= ctrl_of(S_FETCH);
                     r_instret <= r_instret + INSTRET_W'(1);
                  end
               end else if (r_wait == WAIT_LAST) begin
                  r_state <= S_TRAP; r_ctrl <= ctrl_of(S_TRAP);
               end else begin
                  r_wait <= r_wait + CNT_W'(1);
               end
            end
            S_WB_ALU, S_WB_MEM: begin
               r_state   <= S_FETCH; r_ctrl <= ctrl_of(S_FETCH);
               r_instret <= r_instret + INSTRET_W'(1);
            end
            S_TRAP: begin
               r_state <= S_TRAP; r_ctrl <= ctrl_of(S_TRAP);
            end
            default: begin
               r_state <= S_TRAP; r_ctrl <= ctrl_of(S_TRAP);
            end
         endcase
      end
   end

   // Strobes are masked while reset is asserted so an abandoned operation never commits.
   assign bus.mem_req_o    = r_ctrl.mem_req & rst_n_i;
   assign bus.mem_we_o     = r_ctrl.mem_we & rst_n_i;
   assign bus.ir_we_o      = r_ctrl.fetch_en & bus.mem_ready_i & rst_n_i;
   assign bus.pc_we_o      = r_ctrl.fetch_en & bus.mem_ready_i & rst_n_i;
   assign bus.alu_out_we_o = r_ctrl.alu_out_we & rst_n_i;
   assign bus.reg_we_o     = r_ctrl.reg_we & rst_n_i;
   assign bus.addr_sel_o   = r_ctrl.addr_sel;
   assign bus.alu_src_a_o  = r_ctrl.src_a;
   assign bus.alu_src_b_o  = r_ctrl.src_b;
   assign bus.wb_sel_o     = r_ctrl.wb_sel;
   assign bus.trap_o       = r_ctrl.trap;
   assign bus.alu_op_o     = r_alu_op;
   assign bus.state_o      = r_state;
   assign bus.instret_o    = r_instret;

endmodule

// File: tb/tb_multiciclo_control.sv
// Bench for multiciclo_control: a reference model expands each instruction into its
// per-cycle expected trace; a monitor pops one entry per cycle and compares.
`timescale 1ns/1ps
module tb_multiciclo_control;

   localparam int TO    = 4;
   localparam int IW    = 4;
   localparam int EXP_W = 8 + IW;

   localparam logic [6:0] OP_R  = 7'b0110011;
   localparam logic [6:0] OP_I  = 7'b0010011;
   localparam logic [6:0] OP_LD = 7'b0000011;
   localparam logic [6:0] OP_ST = 7'b0100011;

   localparam logic [3:0] ST_FETCH = 4'd0, ST_DECODE = 4'd1, ST_EXEC_R = 4'd2, ST_EXEC_I = 4'd3;
   localparam logic [3:0] ST_ADDR = 4'd4, ST_MEM_RD = 4'd5, ST_MEM_WR = 4'd6;
   localparam logic [3:0] ST_WB_ALU = 4'd7, ST_WB_MEM = 4'd8, ST_TRAP = 4'd15;

   localparam logic [3:0] A_ADD = 4'b0000, A_AND = 4'b0001, A_OR = 4'b0010, A_XOR = 4'b0011;
   localparam logic [3:0] A_SUB = 4'b0100, A_SLT = 4'b0101, A_SLTU = 4'b0110;
   localparam logic [3:0] A_SLL = 4'b1000, A_SRL = 4'b1001, A_SRA = 4'b1010;

   // clock / reset
   logic clk = 1'b0;
   logic rst_n = 1'b0;
   always #5 clk = ~clk;

   multiciclo_control_if #(.INSTRET_W(IW)) bus ();

   multiciclo_control #(.MEM_TIMEOUT(TO), .INSTRET_W(IW)) dut (
      .clk_i   (clk),
      .rst_n_i (rst_n),
      .bus     (bus)
   );

   int n_vec = 0;
   int n_err = 0;

   logic [EXP_W-1:0] exp_q[$];
   logic [EXP_W-1:0] stg_e[$];
   logic             stg_r[$];
   logic [IW-1:0]    m_ir = '0;

   task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
      n_vec++;
      if (act !== exp) begin
         n_err++;
         $display("FAIL %s at %0t: got 0x%0h, expected 0x%0h", name, $time, act, exp);
      end
   endtask

   // reference model
   function automatic logic rnd();
      return 1'($urandom_range(0, 1));
   endfunction

   function automatic logic legal_r(input logic f7, input logic [2:0] f3);
      return !(f7 && f3 != 3'b000 && f3 != 3'b101);
   endfunction

   function automatic logic legal_i(input logic f7, input logic [2:0] f3);
      return !(f7 && f3 == 3'b001);
   endfunction

   function automatic logic [3:0] r_op(input logic f7, input logic [2:0] f3);
      logic [3:0] tbl [16];
      for (int k = 0; k < 16; k++) tbl[k] = A_ADD;
      tbl[4'b0000] = A_ADD;  tbl[4'b1000] = A_SUB;  tbl[4'b0001] = A_SLL;
      tbl[4'b0010] = A_SLT;  tbl[4'b0011] = A_SLTU; tbl[4'b0100] = A_XOR;
      tbl[4'b0101] = A_SRL;  tbl[4'b1101] = A_SRA;  tbl[4'b0110] = A_OR;
      tbl[4'b0111] = A_AND;
      return tbl[{f7, f3}];
   endfunction

   function automatic logic [3:0] i_op(input logic f7, input logic [2:0] f3);
      logic [3:0] tbl [8];
      tbl[0] = A_ADD; tbl[1] = A_SLL; tbl[2] = A_SLT; tbl[3] = A_SLTU;
      tbl[4] = A_XOR; tbl[5] = f7 ? A_SRA : A_SRL; tbl[6] = A_OR; tbl[7] = A_AND;
      return tbl[f3];
   endfunction

   // {mem_req, mem_we, addr_sel, src_a, src_b[1:0], alu_out_we, reg_we, wb_sel, trap}
   function automatic logic [9:0] exp_ctrl(input logic [3:0] st);
      case (st)
         ST_FETCH:  return 10'b1_0_0_0_10_0_0_0_0;
         ST_EXEC_R: return 10'b0_0_0_1_00_1_0_0_0;
         ST_EXEC_I: return 10'b0_0_0_1_01_1_0_0_0;
         ST_ADDR:   return 10'b0_0_0_1_01_1_0_0_0;
         ST_MEM_RD: return 10'b1_0_1_0_00_0_0_0_0;
         ST_MEM_WR: return 10'b1_1_1_0_00_0_0_0_0;
         ST_WB_ALU: return 10'b0_0_0_0_00_0_1_0_0;
         ST_WB_MEM: return 10'b0_0_0_0_00_0_1_1_0;
         ST_TRAP:   return 10'b0_0_0_0_00_0_0_0_1;
         default:   return 10'b0;
      endcase
   endfunction

   task automatic add(input logic [3:0] st, input logic [3:0] op, input logic rdy);
      stg_e.push_back({st, op, m_ir});
      stg_r.push_back(rdy);
   endtask

   task automatic add_trap(input int n);
      for (int k = 0; k < n; k++) add(ST_TRAP, A_ADD, rnd());
   endtask

   // A memory access lasting w not-ready cycles; w >= TO means it times out.
   task automatic add_wait(input logic [3:0] st, input int w, output logic ok);
      if (w >= TO) begin
         for (int k = 0; k < TO; k++) add(st, A_ADD, 1'b0);
         ok = 1'b0;
      end else begin
         for (int k = 0; k < w; k++) add(st, A_ADD, 1'b0);
         add(st, A_ADD, 1'b1);
         ok = 1'b1;
      end
   endtask

   // driver: build the expected trace, hand it to the scoreboard, then play it out
   task automatic issue(input logic [6:0] opc, input logic [2:0] f3, input logic f7,
                        input int wf, input int wm, input bit abort);
      logic ok;
      logic [3:0] mst;
      add_wait(ST_FETCH, wf, ok);
      if (!ok) add_trap(3);
      else begin
         add(ST_DECODE, A_ADD, rnd());
         if (opc == OP_R && legal_r(f7, f3)) begin
            add(ST_EXEC_R, r_op(f7, f3), rnd());
            add(ST_WB_ALU, A_ADD, rnd());
            m_ir = m_ir + 1'b1;
         end else if (opc == OP_I && legal_i(f7, f3)) begin
            add(ST_EXEC_I, i_op(f7, f3), rnd());
            add(ST_WB_ALU, A_ADD, rnd());
            m_ir = m_ir + 1'b1;
         end else if (opc == OP_LD || opc == OP_ST) begin
            add(ST_ADDR, A_ADD, rnd());
            mst = (opc == OP_LD) ? ST_MEM_RD : ST_MEM_WR;
            if (abort) add(mst, A_ADD, 1'b0);
            else begin
               add_wait(mst, wm, ok);
               if (!ok) add_trap(3);
               else begin
                  if (opc == OP_LD) add(ST_WB_MEM, A_ADD, rnd());
                  m_ir = m_ir + 1'b1;
               end
            end
         end else begin
            add_trap(5);
         end
      end
      bus.opcode_i = opc;
      bus.func3_i  = f3;
      bus.func7_i  = f7;
      foreach (stg_e[k]) exp_q.push_back(stg_e[k]);
      for (int k = 0; k < stg_r.size(); k++) begin
         bus.mem_ready_i = stg_r[k];
         @(posedge clk); #1;
      end
      stg_e.delete();
      stg_r.delete();
   endtask

   task automatic do_reset();
      rst_n = 1'b0;
      bus.mem_ready_i = 1'b1;
      @(negedge clk);
      check("rst_strobes_c1", 32'({bus.ir_we_o, bus.pc_we_o, bus.alu_out_we_o, bus.reg_we_o, bus.mem_we_o}), 32'd0);
      @(posedge clk); #1;
      @(negedge clk);
      check("rst_state", 32'(bus.state_o), 32'(ST_FETCH));
      check("rst_instret", 32'(bus.instret_o), 32'd0);
      check("rst_trap", 32'(bus.trap_o), 32'd0);
      check("rst_strobes_c2", 32'({bus.ir_we_o, bus.pc_we_o, bus.alu_out_we_o, bus.reg_we_o, bus.mem_we_o}), 32'd0);
      @(posedge clk); #1;
      rst_n = 1'b1;
      m_ir = '0;
   endtask

   // monitor / scoreboard
   initial begin : monitor
      logic [EXP_W-1:0] e;
      logic [3:0] est, eop;
      logic [IW-1:0] eir;
      forever begin
         @(negedge clk);
         if (rst_n && exp_q.size() > 0) begin
            e = exp_q.pop_front();
            {est, eop, eir} = e;
            check("state", 32'(bus.state_o), 32'(est));
            check("ctrl", 32'({bus.mem_req_o, bus.mem_we_o, bus.addr_sel_o, bus.alu_src_a_o,
                                bus.alu_src_b_o, bus.alu_out_we_o, bus.reg_we_o, bus.wb_sel_o,
                                bus.trap_o}), 32'(exp_ctrl(est)));
            check("alu_op", 32'(bus.alu_op_o), 32'(eop));
            check("instret", 32'(bus.instret_o), 32'(eir));
            check("ir_pc_we", 32'({bus.ir_we_o, bus.pc_we_o}),
                  32'({2{(est == ST_FETCH) && bus.mem_ready_i}}));
         end
      end
   end

   initial begin : stimulus
      logic [6:0] opc;
      logic [2:0] f3;
      logic f7;
      bus.opcode_i    = OP_R;
      bus.func3_i     = 3'b000;
      bus.func7_i     = 1'b0;
      bus.mem_ready_i = 1'b1;
      @(posedge clk); #1;
      do_reset();

      issue(OP_R,  3'b000, 1'b0, 0, 0, 1'b0);
      issue(OP_R,  3'b000, 1'b1, 0, 0, 1'b0);
      issue(OP_R,  3'b001, 1'b0, 0, 0, 1'b0);
      issue(OP_I,  3'b101, 1'b1, 0, 0, 1'b0);
      issue(OP_LD, 3'b010, 1'b0, 0, 3, 1'b0);
      issue(OP_ST, 3'b010, 1'b0, 1, TO - 1, 1'b0);
      issue(OP_I,  3'b000, 1'b0, TO - 1, 0, 1'b0);

      for (int n = 0; n < 40; n++) begin
         case ($urandom_range(0, 3))
            0:       opc = OP_R;
            1:       opc = OP_I;
            2:       opc = OP_LD;
            default: opc = OP_ST;
         endcase
         f3 = 3'($urandom_range(0, 7));
         f7 = rnd();
         if (opc == OP_R && !legal_r(f7, f3)) f7 = 1'b0;
         if (opc == OP_I && !legal_i(f7, f3)) f7 = 1'b0;
         issue(opc, f3, f7, $urandom_range(0, TO - 1), $urandom_range(0, TO - 1), 1'b0);
      end

      issue(OP_ST, 3'b010, 1'b0, 0, 2, 1'b1);
      do_reset();
      issue(OP_R, 3'b110, 1'b0, 0, 0, 1'b0);

      issue(7'b1111111, 3'b000, 1'b0, 0, 0, 1'b0);
      do_reset();
      issue(OP_R, 3'b010, 1'b1, 1, 0, 1'b0);
      do_reset();
      issue(OP_I, 3'b001, 1'b1, 0, 0, 1'b0);
      do_reset();
      issue(OP_R, 3'b000, 1'b0, TO, 0, 1'b0);
      do_reset();
      issue(OP_LD, 3'b010, 1'b0, 0, TO, 1'b0);
      do_reset();
      issue(OP_ST, 3'b010, 1'b0, 2, TO, 1'b0);
      do_reset();
      issue(OP_I, 3'b111, 1'b0, 0, 0, 1'b0);

      @(negedge clk);
      $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
      $finish;
   end

endmodule
